// File: rtl/one_hot_state_monitor_pkg.sv
// Shared defaults and helpers for the one-hot state monitor slice.
package one_hot_state_monitor_pkg;

    localparam int unsigned DEF_N_STATES = 8;
    localparam int unsigned DEF_CNT_W    = 8;

    // Dwell counter ceiling for the default counter width.
    localparam logic [DEF_CNT_W-1:0] DWELL_SAT = '1;

    // Classification of one sampled state vector.
    typedef enum logic [1:0] {
        SMP_LEGAL = 2'd0,
        SMP_NONE  = 2'd1,
        SMP_MULTI = 2'd2
    } sample_class_e;

    // Smallest width able to hold indices 0..n-1 (at least 1 bit).
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/one_hot_state_monitor_if.sv
// Bundle between the one-hot controller side and the monitor.
interface one_hot_state_monitor_if
    import one_hot_state_monitor_pkg::*;
#(
    parameter int unsigned N_STATES = DEF_N_STATES,
    parameter int unsigned IDX_W    = idx_width(N_STATES),
    parameter int unsigned CNT_W    = DEF_CNT_W
);

    logic [N_STATES-1:0] state_vec;
    logic                clr_err;
    logic [IDX_W-1:0]    state_idx;
    logic                state_valid;
    logic                changed;
    logic [CNT_W-1:0]    dwell_cnt;
    logic [CNT_W-1:0]    trans_cnt;
    logic                err_none;
    logic                err_multi;
    logic                err_sticky;

    // Controller / bench side: drives the state bits, reads the monitor view.
    modport master (
        output state_vec, clr_err,
        input  state_idx, state_valid, changed, dwell_cnt, trans_cnt,
               err_none, err_multi, err_sticky
    );

    // Monitor side.
    modport slave (
        input  state_vec, clr_err,
        output state_idx, state_valid, changed, dwell_cnt, trans_cnt,
               err_none, err_multi, err_sticky
    );

endinterface

// File: rtl/one_hot_state_monitor_onehot_decode.sv
// Combinational one-hot decoder: binary index plus zero/multi-hot flags.
// o_idx is only meaningful when neither flag is set.
module onehot_decode
    import one_hot_state_monitor_pkg::*;
#(
    parameter int unsigned N_STATES = DEF_N_STATES,
    parameter int unsigned IDX_W    = idx_width(N_STATES)
) (
    input  logic [N_STATES-1:0] i_state_vec,
    output logic [IDX_W-1:0]    o_idx,
    output logic                o_is_zero,
    output logic                o_is_multi
);

    logic [IDX_W-1:0] w_idx;
    logic             w_any;
    logic             w_multi;

    // OR together the indices of all hot bits; flag a second hot bit as multi.
    always_comb begin
        w_idx   = '0;
        w_any   = 1'b0;
        w_multi = 1'b0;
        for (int unsigned i = 0; i < N_STATES; i++) begin
            if (i_state_vec[i]) begin
                if (w_any) begin
                    w_multi = 1'b1;
                end
                w_any = 1'b1;
                w_idx = w_idx | IDX_W'(i);
            end
        end
    end

    assign o_idx      = w_idx;
    assign o_is_zero  = ~w_any;
    assign o_is_multi = w_multi;

endmodule

// File: rtl/one_hot_state_monitor.sv
// Registered reader of a one-hot controller state vector: binary index,
// transition pulse, dwell/transition counters and encoding health flags.
module one_hot_state_monitor
    import one_hot_state_monitor_pkg::*;
#(
    parameter int unsigned N_STATES = DEF_N_STATES,
    parameter int unsigned IDX_W    = idx_width(N_STATES),
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    one_hot_state_monitor_if.slave  mon
);

    localparam logic [CNT_W-1:0] L_DWELL_SAT = '1;

    logic [IDX_W-1:0] w_dec_idx;
    logic             w_dec_zero;
    logic             w_dec_multi;
    sample_class_e    w_class;

    logic [IDX_W-1:0] r_state_idx,   w_nxt_state_idx;
    logic             r_state_valid, w_nxt_state_valid;
    logic             r_changed,     w_nxt_changed;
    logic [CNT_W-1:0] r_dwell_cnt,   w_nxt_dwell_cnt;
    logic [CNT_W-1:0] r_trans_cnt,   w_nxt_trans_cnt;
    logic             r_err_none,    w_nxt_err_none;
    logic             r_err_multi,   w_nxt_err_multi;
    logic             r_err_sticky,  w_nxt_err_sticky;
    logic             r_seen_first,  w_nxt_seen_first;

    onehot_decode #(
        .N_STATES (N_STATES),
        .IDX_W    (IDX_W)
    ) u_decode (
        .i_state_vec (mon.state_vec),
        .o_idx       (w_dec_idx),
        .o_is_zero   (w_dec_zero),
        .o_is_multi  (w_dec_multi)
    );

    // Classify the current sample as legal, zero-hot or multi-hot.
    always_comb begin
        w_class = SMP_LEGAL;
        if (w_dec_zero) begin
            w_class = SMP_NONE;
        end else if (w_dec_multi) begin
            w_class = SMP_MULTI;
        end
    end

    // Next-state computation for every monitor register.
    always_comb begin
        w_nxt_state_idx   = r_state_idx;
        w_nxt_state_valid = r_state_valid;
        w_nxt_changed     = 1'b0;
        w_nxt_dwell_cnt   = r_dwell_cnt;
        w_nxt_trans_cnt   = r_trans_cnt;
        w_nxt_err_none    = r_err_none;
        w_nxt_err_multi   = r_err_multi;
        w_nxt_err_sticky  = r_err_sticky;
        w_nxt_seen_first  = r_seen_first;

        case (w_class)
            SMP_LEGAL: begin
                w_nxt_state_idx   = w_dec_idx;
                w_nxt_state_valid = 1'b1;
                w_nxt_err_none    = 1'b0;
                w_nxt_err_multi   = 1'b0;
                if (mon.clr_err) begin
                    w_nxt_err_sticky = 1'b0;
                end
                if (!r_seen_first) begin
                    w_nxt_seen_first = 1'b1;
                    w_nxt_dwell_cnt  = CNT_W'(1);
                end else if (w_dec_idx == r_state_idx) begin
                    if (r_dwell_cnt != L_DWELL_SAT) begin
                        w_nxt_dwell_cnt = r_dwell_cnt + 1'b1;
                    end
                end else begin
                    w_nxt_changed   = 1'b1;
                    w_nxt_dwell_cnt = CNT_W'(1);
                    w_nxt_trans_cnt = r_trans_cnt + 1'b1;
                end
            end
            default: begin
                w_nxt_state_valid = 1'b0;
                w_nxt_err_none    = (w_class == SMP_NONE);
                w_nxt_err_multi   = (w_class == SMP_MULTI);
                w_nxt_err_sticky  = 1'b1;
            end
        endcase
    end

    // Single register stage for all outputs; async active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_idx   <= '0;
            r_state_valid <= 1'b0;
            r_changed     <= 1'b0;
            r_dwell_cnt   <= '0;
            r_trans_cnt   <= '0;
            r_err_none    <= 1'b0;
            r_err_multi   <= 1'b0;
            r_err_sticky  <= 1'b0;
            r_seen_first  <= 1'b0;
        end else begin
            r_state_idx   <= w_nxt_state_idx;
            r_state_valid <= w_nxt_state_valid;
            r_changed     <= w_nxt_changed;
            r_dwell_cnt   <= w_nxt_dwell_cnt;
            r_trans_cnt   <= w_nxt_trans_cnt;
            r_err_none    <= w_nxt_err_none;
            r_err_multi   <= w_nxt_err_multi;
            r_err_sticky  <= w_nxt_err_sticky;
            r_seen_first  <= w_nxt_seen_first;
        end
    end

    assign mon.state_idx   = r_state_idx;
    assign mon.state_valid = r_state_valid;
    assign mon.changed     = r_changed;
    assign mon.dwell_cnt   = r_dwell_cnt;
    assign mon.trans_cnt   = r_trans_cnt;
    assign mon.err_none    = r_err_none;
    assign mon.err_multi   = r_err_multi;
    assign mon.err_sticky  = r_err_sticky;

endmodule

// File: tb/tb_one_hot_state_monitor.sv
// Scoreboard bench for one_hot_state_monitor (N_STATES=8, CNT_W=8).
module tb_one_hot_state_monitor;
    import one_hot_state_monitor_pkg::*;

    typedef struct packed {
        logic [2:0] idx;
        logic       valid;
        logic       changed;
        logic [7:0] dwell;
        logic [7:0] trans;
        logic       en;
        logic       em;
        logic       es;
    } exp_t;

    logic clk;
    logic rst;

    one_hot_state_monitor_if #(.N_STATES(8), .IDX_W(3), .CNT_W(8)) bus ();

    one_hot_state_monitor #(.N_STATES(8), .IDX_W(3), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .mon (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   vectors;
    int   miscompares;
    exp_t sb[$];

    // Reference model state.
    logic       m_seen;
    logic [2:0] m_idx;
    int         m_dwell;
    int         m_trans;
    logic       m_sticky;

    function automatic exp_t snap();
        exp_t a;
        a = {bus.state_idx, bus.state_valid, bus.changed, bus.dwell_cnt,
             bus.trans_cnt, bus.err_none, bus.err_multi, bus.err_sticky};
        return a;
    endfunction

    task automatic model_reset();
        m_seen = 1'b0; m_idx = '0; m_dwell = 0; m_trans = 0; m_sticky = 1'b0;
        sb.delete();
    endtask

    // Drive one sample, predict the registered result, wait until it is visible.
    task automatic apply(input logic [7:0] v, input logic c);
        exp_t e;
        int   pc;
        int   k;
        bus.state_vec = v;
        bus.clr_err   = c;
        pc = $countones(v);
        e  = '0;
        if (pc == 1) begin
            k = $clog2(v);
            e.valid = 1'b1;
            if (!m_seen) begin
                m_seen  = 1'b1;
                m_dwell = 1;
            end else if (k == int'(m_idx)) begin
                if (m_dwell < 255) m_dwell = m_dwell + 1;
            end else begin
                e.changed = 1'b1;
                m_dwell   = 1;
                m_trans   = (m_trans + 1) % 256;
            end
            m_idx = 3'(k);
            if (c) m_sticky = 1'b0;
        end else begin
            e.en     = (pc == 0);
            e.em     = (pc >= 2);
            m_sticky = 1'b1;
        end
        e.idx   = m_idx;
        e.dwell = 8'(m_dwell);
        e.trans = 8'(m_trans);
        e.es    = m_sticky;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, a;
        rst = 1'b0;
        bus.state_vec = 8'h01;
        bus.clr_err   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        a = snap(); vectors++;
        if (a !== '0) begin
            miscompares++; $display("FAIL reset_hold act=%h exp=%h", a, exp_t'('0));
        end
        @(negedge clk);
        rst = 1'b1;
        apply(8'h01, 1'b0);
        e = sb.pop_front(); a = snap(); vectors++;
        if (a !== e) begin
            miscompares++; $display("FAIL reset_first act=%h exp=%h", a, e);
        end
        vectors++;
        if (bus.dwell_cnt !== 8'd1 || bus.trans_cnt !== 8'd0 || bus.changed !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_first_const dwell=%0d trans=%0d changed=%b required 1/0/0",
                     bus.dwell_cnt, bus.trans_cnt, bus.changed);
        end
    endtask

    task automatic test_transition();
        exp_t e, a;
        for (int i = 0; i < 4; i++) begin
            apply((i < 2) ? 8'h01 : 8'h04, 1'b0);
            e = sb.pop_front(); a = snap(); vectors++;
            if (a !== e) begin
                miscompares++; $display("FAIL transition step %0d act=%h exp=%h", i, a, e);
            end
            if (i == 1) begin
                vectors++;
                if (bus.dwell_cnt !== 8'd3) begin
                    miscompares++; $display("FAIL transition_dwell3 act=%0d exp=3", bus.dwell_cnt);
                end
            end
            if (i == 2) begin
                vectors++;
                if (bus.state_idx !== 3'd2 || bus.changed !== 1'b1 || bus.dwell_cnt !== 8'd1
                    || bus.trans_cnt !== 8'd1) begin
                    miscompares++;
                    $display("FAIL transition_edge idx=%0d ch=%b dwell=%0d trans=%0d required 2/1/1/1",
                             bus.state_idx, bus.changed, bus.dwell_cnt, bus.trans_cnt);
                end
            end
            if (i == 3) begin
                vectors++;
                if (bus.changed !== 1'b0) begin
                    miscompares++; $display("FAIL transition_pulse act=%b exp=0", bus.changed);
                end
            end
        end
    endtask

    task automatic test_dwell_sat();
        exp_t e, a;
        for (int i = 0; i < 300; i++) begin
            apply(8'h10, 1'b0);
            e = sb.pop_front(); a = snap(); vectors++;
            if (a !== e) begin
                miscompares++; $display("FAIL dwell_sat step %0d act=%h exp=%h", i, a, e);
            end
        end
        vectors++;
        if (bus.dwell_cnt !== DWELL_SAT || bus.state_idx !== 3'd4) begin
            miscompares++;
            $display("FAIL dwell_sat_end dwell=%0d idx=%0d required 255/4", bus.dwell_cnt, bus.state_idx);
        end
    endtask

    task automatic test_zero_hot();
        exp_t e, a;
        logic [7:0] t0;
        logic [7:0] vecs [3];
        vecs[0] = 8'h02; vecs[1] = 8'h00; vecs[2] = 8'h02;
        t0 = '0;
        for (int i = 0; i < 3; i++) begin
            apply(vecs[i], 1'b0);
            e = sb.pop_front(); a = snap(); vectors++;
            if (a !== e) begin
                miscompares++; $display("FAIL zero_hot step %0d act=%h exp=%h", i, a, e);
            end
            if (i == 0) t0 = bus.trans_cnt;
            if (i == 1) begin
                vectors++;
                if (bus.err_none !== 1'b1 || bus.state_valid !== 1'b0 || bus.err_sticky !== 1'b1
                    || bus.state_idx !== 3'd1) begin
                    miscompares++;
                    $display("FAIL zero_hot_flags none=%b valid=%b sticky=%b idx=%0d required 1/0/1/1",
                             bus.err_none, bus.state_valid, bus.err_sticky, bus.state_idx);
                end
            end
            if (i == 2) begin
                vectors++;
                if (bus.dwell_cnt !== 8'd2 || bus.trans_cnt !== t0) begin
                    miscompares++;
                    $display("FAIL zero_hot_resume dwell=%0d trans=%0d required 2/%0d",
                             bus.dwell_cnt, bus.trans_cnt, t0);
                end
            end
        end
    endtask

    task automatic test_multi_clear();
        exp_t e, a;
        apply(8'h18, 1'b1);
        e = sb.pop_front(); a = snap(); vectors++;
        if (a !== e) begin
            miscompares++; $display("FAIL multi act=%h exp=%h", a, e);
        end
        vectors++;
        if (bus.err_multi !== 1'b1 || bus.err_sticky !== 1'b1 || bus.err_none !== 1'b0) begin
            miscompares++;
            $display("FAIL multi_flags multi=%b sticky=%b none=%b required 1/1/0",
                     bus.err_multi, bus.err_sticky, bus.err_none);
        end
        apply(8'h08, 1'b1);
        e = sb.pop_front(); a = snap(); vectors++;
        if (a !== e) begin
            miscompares++; $display("FAIL multi_clear act=%h exp=%h", a, e);
        end
        vectors++;
        if (bus.err_sticky !== 1'b0 || bus.state_idx !== 3'd3) begin
            miscompares++;
            $display("FAIL multi_clear_flags sticky=%b idx=%0d required 0/3", bus.err_sticky, bus.state_idx);
        end
    endtask

    task automatic test_trans_wrap();
        exp_t e, a;
        logic [7:0] t0;
        t0 = bus.trans_cnt;
        for (int i = 0; i < 260; i++) begin
            apply((i % 2 == 0) ? 8'h01 : 8'h02, 1'b0);
            e = sb.pop_front(); a = snap(); vectors++;
            if (a !== e) begin
                miscompares++; $display("FAIL trans_wrap step %0d act=%h exp=%h", i, a, e);
            end
        end
        vectors++;
        if (bus.trans_cnt !== 8'(t0 + 8'd4)) begin
            miscompares++; $display("FAIL trans_wrap_end act=%0d exp=%0d", bus.trans_cnt, 8'(t0 + 8'd4));
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, a;
        logic [7:0] v;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) < 7) v = 8'h01 << $urandom_range(0, 2);
            else                          v = 8'($urandom_range(0, 255));
            apply(v, ($urandom_range(0, 3) == 0));
            e = sb.pop_front(); a = snap(); vectors++;
            if (a !== e) begin
                miscompares++; $display("FAIL back_to_back step %0d vec=%h act=%h exp=%h", i, v, a, e);
            end
        end
    endtask

    task automatic test_mid_reset();
        exp_t e, a;
        for (int i = 0; i < 50; i++) begin
            apply(8'h20, 1'b0);
            e = sb.pop_front(); a = snap(); vectors++;
            if (a !== e) begin
                miscompares++; $display("FAIL mid_reset_dwell step %0d act=%h exp=%h", i, a, e);
            end
        end
        #1;
        rst = 1'b0;
        #1;
        a = snap(); vectors++;
        if (a !== '0) begin
            miscompares++; $display("FAIL mid_reset_async act=%h exp=%h", a, exp_t'('0));
        end
        model_reset();
        @(posedge clk);
        #1;
        a = snap(); vectors++;
        if (a !== '0) begin
            miscompares++; $display("FAIL mid_reset_held act=%h exp=%h", a, exp_t'('0));
        end
        @(negedge clk);
        rst = 1'b1;
        apply(8'h20, 1'b0);
        e = sb.pop_front(); a = snap(); vectors++;
        if (a !== e) begin
            miscompares++; $display("FAIL mid_reset_first act=%h exp=%h", a, e);
        end
        vectors++;
        if (bus.dwell_cnt !== 8'd1 || bus.trans_cnt !== 8'd0 || bus.state_idx !== 3'd5) begin
            miscompares++;
            $display("FAIL mid_reset_const dwell=%0d trans=%0d idx=%0d required 1/0/5",
                     bus.dwell_cnt, bus.trans_cnt, bus.state_idx);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog timeout act=running exp=finished");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_transition();
        test_dwell_sat();
        test_zero_hot();
        test_multi_clear();
        test_trans_wrap();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
